bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment display driver and feeds its 16-bit packed-BCD `data_in`.
- Takes a binary sample (ambient-light reading or scaled value) on a start strobe.
- Holds the converted BCD word stable between updates so the display never shows a partial result.

---
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial binary-to-packed-BCD converter (shift-and-add-3).
// Ports: clk, rst (async high), start, bin_in -> busy, done, bcd_out, overflow.
// Optional: define AUTO_SAMPLE_EN to trigger conversions every SAMPLE_PERIOD clocks.
module bin2bcd_seq #(
  parameter int BIN_W         = 14,
  parameter int DIGITS        = 4,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int OW = 4 * DIGITS;
  localparam int AW = OW + 4;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    acc_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [OW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             go;

`ifdef AUTO_SAMPLE_EN
  localparam int SW = $clog2(SAMPLE_PERIOD);

  logic [SW-1:0] smp_q, smp_d;
  logic          tick;
  logic          unused_start;

  assign unused_start = start;
  assign tick = (smp_q == SW'(SAMPLE_PERIOD - 1));
  assign smp_d = tick ? '0 : smp_q + SW'(1);
  assign go = tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp_q <= '0;
    else     smp_q <= smp_d;
  end
`else
  assign go = start;
`endif

  // Nibbles >= 5 get +3 so the following left shift carries into the next digit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < AW / 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          shreg_d = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = (64'(bin_in) > MAX_VAL);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d   = {acc_adj[AW-2:0], shreg_q[BIN_W-1]};
        shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1))
          state_d = S_LOAD;
      end
      S_LOAD: begin
        // Out-of-range values saturate to all nines instead of wrapping.
        bcd_d   = sat_q ? {DIGITS{4'h9}} : acc_q[OW-1:0];
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // The done cycle still reports busy so done never appears with busy low.
  assign busy     = (state_q != S_IDLE) | done_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq.
// Expected {overflow, bcd_out} queued at start, compared on each done.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd_out;
  logic              overflow;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(
    .BIN_W(BIN_W),
    .DIGITS(DIGITS),
    .SAMPLE_PERIOD(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin_in(bin_in),
    .busy(busy),
    .done(done),
    .bcd_out(bcd_out),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_fn(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return {1'b1, 16'h9999};
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      logic legal;
      n_done++;
      legal = 1'b1;
      for (int i = 0; i < DIGITS; i++)
        if (bcd_out[4*i +: 4] > 4'd9) legal = 1'b0;
      check("done_busy", 32'(busy), 32'd1);
      check("nibble_legal", 32'(legal), 32'd1);
      if (exp_q.size() == 0)
        check("spurious_done", 32'd1, 32'd0);
      else
        check("bcd_result", 32'({overflow, bcd_out}), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic convert(input int v, input bit chk_lat);
    int k;
    wait_idle();
    bin_in = BIN_W'(v);
    start = 1'b1;
    exp_q.push_back(ref_fn(v));
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_lat) check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (chk_lat) check("latency", 32'(k), 32'd15);
    else if (!done) check("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

`ifdef AUTO_SAMPLE_EN
  initial begin
    int t[3];
    int seen;
    int k;
    #12;
    check("rst_bcd", 32'(bcd_out), 32'd0);
    bin_in = 14'd2048;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_fn(2048));
    seen = 0;
    k = 0;
    while (seen < 3 && k < 200) begin
      @(posedge clk); #1;
      if (done) begin
        t[seen] = k;
        seen++;
      end
      k++;
    end
    check("auto_count", 32'(seen), 32'd3);
    if (seen == 3) begin
      check("auto_gap0", 32'(t[1] - t[0]), 32'd40);
      check("auto_gap1", 32'(t[2] - t[1]), 32'd40);
    end
    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
`else
  initial begin
    int d0;
    int t[3];
    int seen;
    int k;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    convert(0, 1);
    convert(1234, 1);
    convert(9999, 1);
    convert(10000, 1);
    convert(7, 1);

    // starts during a conversion and bin_in churn must be ignored
    wait_idle();
    d0 = n_done;
    bin_in = 14'd4321;
    start = 1'b1;
    exp_q.push_back(ref_fn(4321));
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      bin_in = BIN_W'($urandom);
      start = (i == 3 || i == 10);
      if (start) bin_in = 14'd55;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ignore_single_done", 32'(n_done - d0), 32'd1);

    // asynchronous reset in mid conversion
    convert(567, 0);
    wait_idle();
    d0 = n_done;
    bin_in = 14'd890;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    convert(890, 1);

    // start held high: one result per BIN_W+2 clocks
    wait_idle();
    bin_in = 14'd321;
    start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_fn(321));
    seen = 0;
    k = 0;
    while (seen < 3 && k < 100) begin
      @(posedge clk); #1;
      if (done) begin
        t[seen] = k;
        seen++;
        if (seen == 3) start = 1'b0;
      end
      k++;
    end
    start = 1'b0;
    check("tput_count", 32'(seen), 32'd3);
    if (seen == 3) begin
      check("tput_first", 32'(t[0]), 32'd15);
      check("tput_gap0", 32'(t[1] - t[0]), 32'd16);
      check("tput_gap1", 32'(t[2] - t[1]), 32'd16);
    end
    @(posedge clk); #1;

    for (int v = 0; v < 1000; v++) convert(v, 0);
    for (int v = 9990; v <= 10010; v++) convert(v, 0);
    convert(16383, 1);
    for (int i = 0; i < 30; i++) convert(int'($urandom_range(16383, 0)), 0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
`endif

endmodule
